// File: rtl/fan_pkg.sv
// Shared fan-control definitions: ramp FSM state encoding and default duty geometry,
// also used by the downstream PWM block.
package fan_pkg;

  typedef enum logic [1:0] {
    FAN_IDLE      = 2'd0,
    FAN_RAMP_UP   = 2'd1,
    FAN_RAMP_DOWN = 2'd2
  } fan_state_t;

  localparam int FAN_DUTY_W    = 7;
  localparam int FAN_DUTY_STEP = 30;

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for an already-debounced button level; a held level yields one event.
module btn_edge_detect (
  input  logic clk,
  input  logic reset_p,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clk) begin
    if (reset_p) in_q <= 1'b0;
    else         in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/fan_speed_ramp.sv
// Fan duty controller: buttons select a speed level, and the duty output slews toward
// that level's target by one LSB every RAMP_TICKS clocks.
module fan_speed_ramp
  import fan_pkg::*;
#(
  parameter  int NUM_LEVELS = 4,
  parameter  int DUTY_STEP  = FAN_DUTY_STEP,
  parameter  int DUTY_W     = FAN_DUTY_W,
  parameter  int RAMP_TICKS = 1000000,
  localparam int LVL_W      = (NUM_LEVELS > 2) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              btn,
  input  logic              btn_off,
  output logic [DUTY_W-1:0] duty,
  output logic [LVL_W-1:0]  level,
  output logic              ramping
);

  localparam int               PS_W    = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_LEVELS - 1);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(RAMP_TICKS - 1);

  function automatic logic [DUTY_W-1:0] level_target(input logic [LVL_W-1:0] lvl);
    return DUTY_W'(int'(lvl) * DUTY_STEP);
  endfunction

  // One LSB toward the target; callers guarantee cur != tgt, so this cannot wrap.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    return (tgt > cur) ? cur + DUTY_W'(1) : cur - DUTY_W'(1);
  endfunction

  logic              btn_rise;
  logic              off_rise;
  logic [DUTY_W-1:0] target;
  logic [DUTY_W-1:0] duty_next;
  logic [PS_W-1:0]   prescaler;
  fan_state_t        state;

  btn_edge_detect u_btn_edge (
    .clk     (clk),
    .reset_p (reset_p),
    .in      (btn),
    .rise    (btn_rise)
  );

  btn_edge_detect u_off_edge (
    .clk     (clk),
    .reset_p (reset_p),
    .in      (btn_off),
    .rise    (off_rise)
  );

  // Off button has priority when both edges land on the same clock.
  always_ff @(posedge clk) begin
    if (reset_p)       level <= '0;
    else if (off_rise) level <= '0;
    else if (btn_rise) level <= (level == LVL_MAX) ? '0 : level + LVL_W'(1);
  end

  assign target    = level_target(level);
  assign duty_next = step_toward(duty, target);

  // Direction is recomputed every cycle from target vs duty; the prescaler keeps running
  // across a retarget so the step cadence is preserved.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state     <= FAN_IDLE;
      duty      <= '0;
      prescaler <= '0;
      ramping   <= 1'b0;
    end else begin
      case (state)
        FAN_IDLE: begin
          prescaler <= '0;
          if (target > duty) begin
            state   <= FAN_RAMP_UP;
            ramping <= 1'b1;
          end else if (target < duty) begin
            state   <= FAN_RAMP_DOWN;
            ramping <= 1'b1;
          end
        end
        default: begin
          if (target == duty) begin
            state   <= FAN_IDLE;
            ramping <= 1'b0;
          end else if (prescaler == PS_LAST) begin
            prescaler <= '0;
            duty      <= duty_next;
            if (duty_next == target) begin
              state   <= FAN_IDLE;
              ramping <= 1'b0;
            end else begin
              state   <= (target > duty) ? FAN_RAMP_UP : FAN_RAMP_DOWN;
              ramping <= 1'b1;
            end
          end else begin
            prescaler <= prescaler + PS_W'(1);
            state     <= (target > duty) ? FAN_RAMP_UP : FAN_RAMP_DOWN;
            ramping   <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fan_speed_ramp.sv
// Bench for fan_speed_ramp: directed scenarios with literal expectations plus random button
// traffic, all compared every cycle against a behavioural model of the slew controller.
module tb_fan_speed_ramp;

  localparam int NUM_LEVELS = 4;
  localparam int DUTY_STEP  = 30;
  localparam int DUTY_W     = 7;
  localparam int RAMP_TICKS = 2;
  localparam int LVL_W      = 2;

  logic              clk = 1'b0;
  logic              reset_p = 1'b1;
  logic              btn = 1'b0;
  logic              btn_off = 1'b0;
  logic [DUTY_W-1:0] duty;
  logic [LVL_W-1:0]  level;
  logic              ramping;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fan_speed_ramp #(
    .NUM_LEVELS (NUM_LEVELS),
    .DUTY_STEP  (DUTY_STEP),
    .DUTY_W     (DUTY_W),
    .RAMP_TICKS (RAMP_TICKS)
  ) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .btn     (btn),
    .btn_off (btn_off),
    .duty    (duty),
    .level   (level),
    .ramping (ramping)
  );

  // Reference: level from button events, duty moves one unit each time the cycles spent
  // ramping reach a multiple of RAMP_TICKS; the count restarts only after settling.
  int m_level = 0;
  int m_duty = 0;
  int m_elapsed = 0;
  bit m_ramp = 0;
  bit m_btn_q = 0;
  bit m_off_q = 0;
  bit model_live = 0;

  always @(posedge clk) begin
    int tgt;
    bit rb;
    bit ro;
    if (reset_p) begin
      m_level = 0; m_duty = 0; m_elapsed = 0; m_ramp = 0;
      m_btn_q = 0; m_off_q = 0; model_live = 1;
    end else begin
      rb = btn && !m_btn_q;
      ro = btn_off && !m_off_q;
      m_btn_q = btn;
      m_off_q = btn_off;
      tgt = m_level * DUTY_STEP;
      if (!m_ramp) begin
        m_ramp = (tgt != m_duty);
        m_elapsed = 0;
      end else if (tgt == m_duty) begin
        m_ramp = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed % RAMP_TICKS == 0) begin
          m_duty += (tgt > m_duty) ? 1 : -1;
          if (m_duty == tgt) m_ramp = 0;
        end
      end
      if (ro)      m_level = 0;
      else if (rb) m_level = (m_level + 1) % NUM_LEVELS;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      checks++;
      if (duty !== DUTY_W'(m_duty) || level !== LVL_W'(m_level) || ramping !== m_ramp) begin
        errors++;
        $display("FAIL model_cmp t=%0t duty=%0d exp %0d level=%0d exp %0d ramping=%0d exp %0d",
                 $time, duty, m_duty, level, m_level, ramping, m_ramp);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic pulse_btn();
    btn = 1'b1;
    step();
    btn = 1'b0;
    step();
  endtask

  task automatic settle(input string name);
    int n = 0;
    step(2);
    while (ramping && n < 400) begin
      step();
      n++;
    end
    chk(name, ramping, 0);
  endtask

  task automatic wait_duty(input int v, input string name);
    int n = 0;
    while (duty != DUTY_W'(v) && n < 400) begin
      step();
      n++;
    end
    chk(name, duty, v);
  endtask

  initial begin
    // Reset held with btn high; the cleared history makes the release count as one press.
    btn = 1'b1;
    step(3);
    chk("rst_duty", duty, 0);
    chk("rst_level", level, 0);
    chk("rst_ramping", ramping, 0);
    reset_p = 1'b0;
    step();
    chk("rel_level", level, 1);
    chk("rel_ramping", ramping, 0);
    step();
    chk("entry_ramping", ramping, 1);
    chk("entry_duty", duty, 0);
    step(2);
    chk("first_step", duty, 1);
    step(56);
    chk("pre_final_duty", duty, 29);
    chk("pre_final_ramping", ramping, 1);
    step(2);
    chk("final_duty", duty, 30);
    chk("final_ramping", ramping, 0);
    btn = 1'b0;
    step(5);
    chk("held_stable", duty, 30);

    // Wrap through all levels from a clean reset.
    reset_p = 1'b1;
    step();
    reset_p = 1'b0;
    pulse_btn(); chk("wrap_l1", level, 1); settle("wrap_s1"); chk("wrap_d1", duty, 30);
    pulse_btn(); chk("wrap_l2", level, 2); settle("wrap_s2"); chk("wrap_d2", duty, 60);
    pulse_btn(); chk("wrap_l3", level, 3); settle("wrap_s3"); chk("wrap_d3", duty, 90);
    pulse_btn(); chk("wrap_l0", level, 0); settle("wrap_s0"); chk("wrap_d0", duty, 0);

    // Retarget mid-ramp, then reverse direction with the off button.
    pulse_btn();
    pulse_btn();
    chk("rt_level2", level, 2);
    wait_duty(40, "rt_reach40");
    pulse_btn();
    chk("rt_level3", level, 3);
    wait_duty(50, "rt_reach50");
    btn_off = 1'b1;
    step();
    btn_off = 1'b0;
    chk("rt_off_level", level, 0);
    settle("rt_settle");
    chk("rt_final_duty", duty, 0);

    // Both buttons rising on the same clock.
    pulse_btn();
    pulse_btn();
    chk("sim_pre_level", level, 2);
    btn = 1'b1;
    btn_off = 1'b1;
    step();
    chk("sim_level", level, 0);
    btn = 1'b0;
    btn_off = 1'b0;
    settle("sim_settle");

    // Reset in the middle of a ramp.
    pulse_btn();
    pulse_btn();
    wait_duty(45, "mid_reach45");
    reset_p = 1'b1;
    step();
    chk("mid_rst_duty", duty, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ramping", ramping, 0);
    reset_p = 1'b0;
    step();

    // Random button traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0)   btn = ~btn;
      if ($urandom_range(0, 59) == 0)  btn_off = ~btn_off;
      reset_p = ($urandom_range(0, 599) == 0);
      step();
    end
    reset_p = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
